// File: rtl/dht_frame_decoder.sv
// DHT11 frame decoder: gathers 40 serial bits MSB-first, verifies the byte checksum,
// and publishes humidity/temperature with result strobes and a saturating error count.
module dht_frame_decoder #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned BIT_TIMEOUT = 10000,
  parameter int unsigned TO_W        = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       bit_valid,
  input  logic       bit_data,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec,
  output logic       frame_valid,
  output logic       crc_err,
  output logic       timeout_err,
  output logic       busy,
  output logic [7:0] err_count
);

  if ((2 ** TO_W) <= BIT_TIMEOUT || CLK_HZ == 0) begin : g_param_check
    $error("dht_frame_decoder: TO_W too narrow for BIT_TIMEOUT, or CLK_HZ is zero");
  end

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_e;

  state_e            state_q, state_d;
  logic [39:0]       shift_q, shift_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]        hum_int_q, hum_int_d;
  logic [7:0]        hum_dec_q, hum_dec_d;
  logic [7:0]        temp_int_q, temp_int_d;
  logic [7:0]        temp_dec_q, temp_dec_d;
  logic              frame_valid_q, frame_valid_d;
  logic              crc_err_q, crc_err_d;
  logic              timeout_err_q, timeout_err_d;
  logic [7:0]        err_count_q, err_count_d;
  logic [9:0]        sum;

  assign sum = {2'b00, shift_q[39:32]} + {2'b00, shift_q[31:24]}
             + {2'b00, shift_q[23:16]} + {2'b00, shift_q[15:8]};

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    to_cnt_d      = to_cnt_q;
    hum_int_d     = hum_int_q;
    hum_dec_d     = hum_dec_q;
    temp_int_d    = temp_int_q;
    temp_dec_d    = temp_dec_q;
    frame_valid_d = 1'b0;
    crc_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    err_count_d   = err_count_q;

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d   = COLLECT;
          bit_cnt_d = '0;
          to_cnt_d  = '0;
        end
      end
      COLLECT: begin
        // frame_start outranks a coincident bit so a restart always begins clean
        if (frame_start) begin
          bit_cnt_d = '0;
          to_cnt_d  = '0;
        end else if (bit_valid) begin
          shift_d   = {shift_q[38:0], bit_data};
          bit_cnt_d = bit_cnt_q + 6'd1;
          to_cnt_d  = '0;
          if (bit_cnt_q == 6'd39) state_d = CHECK;
        end else if (to_cnt_q == TO_W'(BIT_TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      CHECK: begin
        if (sum[7:0] == shift_q[7:0]) begin
          hum_int_d     = shift_q[39:32];
          hum_dec_d     = shift_q[31:24];
          temp_int_d    = shift_q[23:16];
          temp_dec_d    = shift_q[15:8];
          frame_valid_d = 1'b1;
        end else begin
          crc_err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if ((crc_err_d || timeout_err_d) && err_count_q != 8'hFF)
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      to_cnt_q      <= '0;
      hum_int_q     <= '0;
      hum_dec_q     <= '0;
      temp_int_q    <= '0;
      temp_dec_q    <= '0;
      frame_valid_q <= 1'b0;
      crc_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      to_cnt_q      <= to_cnt_d;
      hum_int_q     <= hum_int_d;
      hum_dec_q     <= hum_dec_d;
      temp_int_q    <= temp_int_d;
      temp_dec_q    <= temp_dec_d;
      frame_valid_q <= frame_valid_d;
      crc_err_q     <= crc_err_d;
      timeout_err_q <= timeout_err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign hum_int     = hum_int_q;
  assign hum_dec     = hum_dec_q;
  assign temp_int    = temp_int_q;
  assign temp_dec    = temp_dec_q;
  assign frame_valid = frame_valid_q;
  assign crc_err     = crc_err_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != IDLE);
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_dht_frame_decoder.sv
// Scoreboard bench for dht_frame_decoder: a byte-level reference model queues expected
// result events; a negedge monitor pops and compares whenever a result strobe appears.
module tb_dht_frame_decoder;

  localparam int unsigned BT = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_data = 1'b0;
  logic [7:0] hum_int, hum_dec, temp_int, temp_dec, err_count;
  logic       frame_valid, crc_err, timeout_err, busy;

  dht_frame_decoder #(.CLK_HZ(50000000), .BIT_TIMEOUT(BT), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_valid(bit_valid),
    .bit_data(bit_data), .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int),
    .temp_dec(temp_dec), .frame_valid(frame_valid), .crc_err(crc_err),
    .timeout_err(timeout_err), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // kind: 0 = frame_valid, 1 = crc_err, 2 = timeout_err
  typedef struct {
    int        kind;
    logic [31:0] data;
    logic [7:0]  ec;
    longint      cyc;
  } ev_t;
  ev_t exp_q[$];

  // reference model state
  logic [31:0] m_data = '0;
  int          m_ec = 0;
  longint      last_cyc = 0;

  function automatic void check(string nm, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void bump_err();
    if (m_ec < 255) m_ec++;
  endfunction

  function automatic void push_frame(logic [39:0] fr, longint at);
    ev_t e;
    int  s;
    s = (int'(fr[39:32]) + int'(fr[31:24]) + int'(fr[23:16]) + int'(fr[15:8])) % 256;
    if (s == int'(fr[7:0])) begin
      m_data = fr[39:8];
      e.kind = 0;
    end else begin
      bump_err();
      e.kind = 1;
    end
    e.data = m_data;
    e.ec   = 8'(m_ec);
    e.cyc  = at;
    exp_q.push_back(e);
  endfunction

  function automatic void push_timeout(longint at);
    ev_t e;
    bump_err();
    e.kind = 2;
    e.data = m_data;
    e.ec   = 8'(m_ec);
    e.cyc  = at;
    exp_q.push_back(e);
  endfunction

  function automatic logic [39:0] mk_frame(bit good);
    logic [7:0] b [5];
    int s;
    for (int i = 4; i >= 1; i--) b[i] = 8'($urandom_range(0, 255));
    s = (int'(b[4]) + int'(b[3]) + int'(b[2]) + int'(b[1])) % 256;
    b[0] = good ? 8'(s) : 8'(s + int'($urandom_range(1, 255)));
    return {b[4], b[3], b[2], b[1], b[0]};
  endfunction

  always @(negedge clk) begin
    if (rst_n && (frame_valid || crc_err || timeout_err)) begin
      ev_t e;
      int  k;
      check("one_hot", int'(frame_valid) + int'(crc_err) + int'(timeout_err), 1);
      k = frame_valid ? 0 : (crc_err ? 1 : 2);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", k, cyc);
      end else begin
        e = exp_q.pop_front();
        check("ev_kind", k, e.kind);
        check("ev_cycle", cyc, e.cyc);
        check("ev_data", {hum_int, hum_dec, temp_int, temp_dec}, e.data);
        check("ev_err_count", err_count, e.ec);
      end
    end
  end

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_pulse(bit with_bit);
    frame_start = 1'b1;
    bit_valid   = with_bit;
    bit_data    = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    bit_valid   = 1'b0;
  endtask

  task automatic send_bit(bit b);
    bit_valid = 1'b1;
    bit_data  = b;
    @(posedge clk); #1;
    last_cyc  = cyc;
    bit_valid = 1'b0;
  endtask

  task automatic send_frame(logic [39:0] fr, int gmin, int gmax);
    for (int i = 39; i >= 0; i--) begin
      send_bit(fr[i]);
      if (i == 0) push_frame(fr, last_cyc + 1);
      else idle(int'($urandom_range(gmax, gmin)));
    end
    idle(2);
  endtask

  task automatic wait_drain(string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin idle(1); n++; end
    check(nm, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] fr;
    idle(3);
    check("reset_data", {hum_int, hum_dec, temp_int, temp_dec}, 0);
    check("reset_err_count", err_count, 0);
    check("reset_busy", busy, 0);
    check("reset_pulses", {frame_valid, crc_err, timeout_err}, 0);
    rst_n = 1'b1;
    idle(2);

    // fixed good frame, 50-cycle gaps
    start_pulse(0);
    check("busy_collect", busy, 1);
    send_frame(40'h37_00_19_00_50, 50, 50);
    wait_drain("drain_good");
    check("good_data", {hum_int, hum_dec, temp_int, temp_dec}, 32'h37_00_19_00);
    check("good_err_count", err_count, 0);

    // bad checksum
    start_pulse(0);
    send_frame(40'h37_00_19_00_51, 50, 50);
    wait_drain("drain_bad");
    check("bad_err_count", err_count, 1);

    // timeout after 20 bits
    start_pulse(0);
    for (int i = 0; i < 20; i++) begin send_bit(1'($urandom_range(0, 1))); idle(3); end
    push_timeout(last_cyc + BT);
    idle(int'(BT) + 3);
    check("timeout_busy", busy, 0);
    wait_drain("drain_timeout");
    start_pulse(0);
    send_frame(40'h41_02_1A_05_62, 0, 5);
    wait_drain("drain_after_to");

    // restart: second frame_start coincides with a strobe that must be dropped
    start_pulse(0);
    for (int i = 0; i < 15; i++) begin send_bit(1'($urandom_range(0, 1))); idle(2); end
    start_pulse(1);
    send_frame(40'h37_00_19_00_50, 0, 4);
    wait_drain("drain_restart");

    // randomized frames, mix of good and bad
    for (int f = 0; f < 20; f++) begin
      start_pulse(0);
      send_frame(mk_frame($urandom_range(0, 3) != 0), 0, 5);
    end
    wait_drain("drain_random");

    // asynchronous reset mid-frame
    start_pulse(0);
    for (int i = 0; i < 30; i++) begin send_bit(1'($urandom_range(0, 1))); idle(1); end
    #3 rst_n = 1'b0;
    #1;
    m_data = '0;
    m_ec   = 0;
    check("midreset_data", {hum_int, hum_dec, temp_int, temp_dec}, 0);
    check("midreset_err_count", err_count, 0);
    check("midreset_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(BT + 5);
    start_pulse(0);
    send_frame(40'h37_00_19_00_50, 0, 3);
    wait_drain("drain_after_reset");

    // saturation
    for (int f = 0; f < 260; f++) begin
      start_pulse(0);
      send_frame(mk_frame(1'b0), 0, 0);
    end
    wait_drain("drain_sat");
    check("sat_err_count", err_count, 255);

    // strobes in IDLE must do nothing
    for (int i = 0; i < 50; i++) begin send_bit(1'($urandom_range(0, 1))); idle(1); end
    idle(5);
    check("idle_busy", busy, 0);
    check("idle_err_count", err_count, 255);
    check("final_data", {hum_int, hum_dec, temp_int, temp_dec}, m_data);
    check("final_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dht_frame_decoder.md
Name: dht_frame_decoder

Overview:
- Consumes the serial bit stream produced by the DHT11 line-timing reader: one strobe per decoded data bit, plus a start strobe when the sensor response is detected.
- Assembles 40 bits MSB-first, verifies the checksum, and publishes humidity and temperature registers with a one-cycle valid strobe.
- Flags checksum failures and stalled frames, and keeps a saturating error count for the status logic downstream.

Parameters:
- CLK_HZ, 50000000, system clock frequency; informational only, no logic depends on it.
- BIT_TIMEOUT, 10000, max cycles allowed between consecutive bit strobes inside a frame (200 us at 50 MHz).
- TO_W, 14, width of the inter-bit timeout counter; must satisfy 2^TO_W > BIT_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse: sensor response detected, frame begins.
- bit_valid  in  1  one-cycle pulse: bit_data holds a decoded bit.
- bit_data  in  1  decoded bit value (1 = long high pulse).
- hum_int  out  8  humidity integer byte, last good frame.
- hum_dec  out  8  humidity decimal byte, last good frame.
- temp_int  out  8  temperature integer byte, last good frame.
- temp_dec  out  8  temperature decimal byte, last good frame.
- frame_valid  out  1  one-cycle pulse: new good frame published.
- crc_err  out  1  one-cycle pulse: 40 bits received, checksum mismatch.
- timeout_err  out  1  one-cycle pulse: frame abandoned on bit timeout.
- busy  out  1  high while in COLLECT or CHECK.
- err_count  out  8  saturating count of crc_err plus timeout_err events.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all data outputs 0x00; frame_valid, crc_err, timeout_err and busy at 0; err_count 0; shift register, bit counter and timeout counter cleared.
- Reset mid-frame aborts with no error pulse and no err_count increment.
- States:
  - IDLE: bit_valid ignored. frame_start -> COLLECT, with bit_cnt=0 and to_cnt=0.
  - COLLECT:
    - On bit_valid: shift bit_data into the LSB of a 40-bit shift register, bit_cnt+1, to_cnt=0.
    - Otherwise to_cnt+1.
    - When the 40th bit is accepted (bit_cnt 39 -> 40): go to CHECK.
    - When to_cnt reaches BIT_TIMEOUT-1 with no bit_valid: pulse timeout_err, go to IDLE.
  - CHECK (exactly one cycle): bytes B4..B0 are taken MSB-first, B4 first received.
    - If (B4+B3+B2+B1) mod 256 == B0: load hum_int=B4, hum_dec=B3, temp_int=B2, temp_dec=B1 and pulse frame_valid.
    - Otherwise pulse crc_err and leave the data outputs unchanged.
    - Go to IDLE.
- Latency: the edge that samples the 40th bit_valid is edge k. Data outputs update and the pulse appears at edge k+1, held for one cycle.
- frame_start while in COLLECT: restart. Clear bit_cnt and to_cnt, stay in COLLECT, no error pulse.
- frame_start and bit_valid in the same cycle: frame_start wins and the bit is dropped.
- frame_start while in CHECK: ignored. The CHECK result still completes.
- bit_valid while in CHECK: ignored.
- Checksum sum is 10-bit internally; only the low 8 bits are compared.
- err_count increments by 1 on each crc_err or timeout_err pulse and saturates at 255. It is cleared only by reset.
- At most one of frame_valid, crc_err, timeout_err is high in any cycle.
- Data outputs are never partially updated.

Test Plan:
- Good frame: frame_start, then 40 bits of 0x37 00 19 00 50, with gaps of 50 cycles. Expect hum_int=0x37, hum_dec=0x00, temp_int=0x19, temp_dec=0x00, and frame_valid high for 1 cycle one edge after the 40th strobe. err_count stays 0.
- Bad checksum: the same frame with last byte 0x51. Expect crc_err pulse, outputs still holding the previous frame's values, err_count=1.
- Timeout: frame_start, 20 bits, then idle. Expect timeout_err exactly BIT_TIMEOUT cycles after the 20th strobe, then state IDLE with busy=0. A later good frame decodes correctly.
- Restart: frame_start, 15 random bits, frame_start, then the full good frame 0x37 00 19 00 50. Expect a single frame_valid with the correct values and no error pulses.
- Reset mid-frame: assert rst_n=0 asynchronously after 30 bits. Expect all outputs 0 immediately, no pulse after release, and the next full frame decodes correctly.
- Saturation: 260 consecutive bad-checksum frames. Expect err_count=255 and holding; bit_valid strobes in IDLE produce no activity.
